// File: rtl/mod_add256.sv
// Sequential 256-bit modular adder: (a + b) mod n over four passes of one
// shared 128-bit carry-select adder (two add passes, two subtract passes).

module csa128 (
  input  logic [127:0] A,
  input  logic [127:0] B,
  input  logic         Cin,
  output logic [127:0] S,
  output logic         Cout
);

  logic [64:0] lo_sum;
  logic [64:0] hi_sum0;
  logic [64:0] hi_sum1;

  // Upper half is precomputed for both carry values; the low carry picks one.
  always_comb begin
    lo_sum  = {1'b0, A[63:0]} + {1'b0, B[63:0]} + {64'd0, Cin};
    hi_sum0 = {1'b0, A[127:64]} + {1'b0, B[127:64]};
    hi_sum1 = {1'b0, A[127:64]} + {1'b0, B[127:64]} + 65'd1;
    if (lo_sum[64]) begin
      S    = {hi_sum1[63:0], lo_sum[63:0]};
      Cout = hi_sum1[64];
    end else begin
      S    = {hi_sum0[63:0], lo_sum[63:0]};
      Cout = hi_sum0[64];
    end
  end

endmodule

module mod_add256 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] a,
  input  logic [255:0] b,
  input  logic [255:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] result,
  output logic         out_sub
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD_LO = 3'd1,
    ADD_HI = 3'd2,
    SUB_LO = 3'd3,
    SUB_HI = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] a_q, a_d;
  logic [255:0] b_q, b_d;
  logic [255:0] n_q, n_d;
  logic [256:0] s_q, s_d;
  logic         c0_q, c0_d;
  logic [127:0] d_lo_q, d_lo_d;
  logic         c1_q, c1_d;
  logic [255:0] result_q, result_d;
  logic         out_sub_q, out_sub_d;

  logic [127:0] csa_a;
  logic [127:0] csa_b;
  logic         csa_cin;
  logic [127:0] csa_s;
  logic         csa_cout;
  logic         ge;

  csa128 u_csa (
    .A    (csa_a),
    .B    (csa_b),
    .Cin  (csa_cin),
    .S    (csa_s),
    .Cout (csa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      s_q       <= '0;
      c0_q      <= 1'b0;
      d_lo_q    <= '0;
      c1_q      <= 1'b0;
      result_q  <= '0;
      out_sub_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      n_q       <= n_d;
      s_q       <= s_d;
      c0_q      <= c0_d;
      d_lo_q    <= d_lo_d;
      c1_q      <= c1_d;
      result_q  <= result_d;
      out_sub_q <= out_sub_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    n_d       = n_q;
    s_d       = s_q;
    c0_d      = c0_q;
    d_lo_d    = d_lo_q;
    c1_d      = c1_q;
    result_d  = result_q;
    out_sub_d = out_sub_q;
    csa_a     = '0;
    csa_b     = '0;
    csa_cin   = 1'b0;
    ge        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          state_d = ADD_LO;
        end
      end
      ADD_LO: begin
        csa_a         = a_q[127:0];
        csa_b         = b_q[127:0];
        s_d[127:0]    = csa_s;
        c0_d          = csa_cout;
        state_d       = ADD_HI;
      end
      ADD_HI: begin
        csa_a         = a_q[255:128];
        csa_b         = b_q[255:128];
        csa_cin       = c0_q;
        s_d[255:128]  = csa_s;
        s_d[256]      = csa_cout;
        state_d       = SUB_LO;
      end
      SUB_LO: begin
        csa_a         = s_q[127:0];
        csa_b         = ~n_q[127:0];
        csa_cin       = 1'b1;
        d_lo_d        = csa_s;
        c1_d          = csa_cout;
        state_d       = SUB_HI;
      end
      SUB_HI: begin
        // The 257-bit sum is >= n when either it overflowed 2^256 or s - n did not borrow.
        csa_a         = s_q[255:128];
        csa_b         = ~n_q[255:128];
        csa_cin       = c1_q;
        ge            = s_q[256] | csa_cout;
        result_d      = ge ? {csa_s, d_lo_q} : s_q[255:0];
        out_sub_d     = ge;
        state_d       = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign out_sub   = out_sub_q;

endmodule

// File: doc/mod_add256.md
# mod_add256

Sequential 256-bit modular adder for the RSA-256 datapath: computes (a + b) mod n. It is the stage directly upstream of, and the sole driver of, one shared CSA128 128-bit carry-select adder instance, which it sequences over four passes (two add, two subtract). Its results feed the modular-exponentiation control. It uses valid/ready handshakes on both sides.

## Interface
- None. Widths are fixed: 256-bit operands, 128-bit adder slice (CSA128: A, B, Cin, S, Cout).

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block idle, can accept operands
- a  input  256  addend, must satisfy a < n
- b  input  256  addend, must satisfy b < n
- n  input  256  modulus
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  256  (a + b) mod n
- out_sub  output  1  1 = n was subtracted

## Operation
- States: IDLE, ADD_LO, ADD_HI, SUB_LO, SUB_HI, HOLD.
- in_ready = (state == IDLE). out_valid = (state == HOLD).
- IDLE:
  - When in_valid && in_ready at a clock edge, latch a, b, n and go to ADD_LO.
  - in_valid is ignored in every other state.
- ADD_LO: CSA128 computes a[127:0] + b[127:0] with Cin=0. Register s[127:0] and carry c0.
- ADD_HI: CSA128 computes a[255:128] + b[255:128] with Cin=c0. Register s[255:128] and s[256] = Cout.
- SUB_LO: CSA128 computes s[127:0] + ~n[127:0] with Cin=1. Register d[127:0] and carry c1.
- SUB_HI: CSA128 computes s[255:128] + ~n[255:128] with Cin=c1. Register d[255:128] and c2 = Cout.
  - ge = s[256] | c2 (the 257-bit sum is >= n).
  - result <= ge ? d : s[255:0]; out_sub <= ge. Go to HOLD.
- HOLD: result and out_sub are held stable. When out_ready is high at an edge, go to IDLE.
- Arithmetic is exact modulo 2^256. If the precondition is violated (a or b >= n), the output is still deterministic per the rule above; no error flag is raised.
- The CSA128 is purely combinational. Its inputs are muxed by state and are 0 in IDLE and HOLD.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, out_sub=0. All internal s/d/carry registers are cleared. Any in-flight operation is discarded with no output. Registers leave reset on the first clk edge after rst_n rises.
- Accept edge E0 moves the block to ADD_LO. Edges E1–E4 perform the four passes.
- out_valid rises after E4: latency is 4 cycles from the accepting edge to out_valid.
- With out_ready held high, the transfer occurs at E5 and in_ready is high again after E5. Peak throughput is one operation per 6 cycles. There is no bypass from HOLD to ADD_LO.
- out_ready low in HOLD stalls indefinitely with no change to result or out_sub.
- out_ready is don't-care outside HOLD.
- a, b, n need only be valid at the accepting edge. Later changes have no effect.
- There is one critical path per cycle: a single CSA128 pass plus the operand mux.

## Test plan
- Basic reduce: a=5, b=7, n=11 → result=1, out_sub=1. out_valid rises exactly 4 cycles after acceptance. in_ready is low for cycles 1–5.
- No reduce: a=3, b=4, n=11 → result=7, out_sub=0.
- Exact modulus: a=6, b=5, n=11 → result=0, out_sub=1.
- Carry across the 128-bit boundary: a=2^128−1, b=1, n=2^255 → result=2^128, out_sub=0.
- 257-bit overflow: n=2^256−1, a=b=2^256−2 → result=2^256−3, out_sub=1, which exercises the s[256] path.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in HOLD: result stays constant, and in_valid pulses are ignored.
  - Next operation: assert rst_n=0 during SUB_LO. Immediately out_valid=0, in_ready=1, result=0.
  - After release, a new operation a=1, b=1, n=3 completes with result=2.
